// File: rtl/exe_unit_w2.sv
// exe_unit_w2: handshaked execution unit with registered result/status.
// Single-cycle ALU ops plus iterative signed multiply and divide on operand magnitudes.
module exe_unit_w2 #(
  parameter int m = 8,
  parameter int n = 3
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [n-1:0] i_oper,
  input  logic [m-1:0] i_argA,
  input  logic [m-1:0] i_argB,
  output logic         o_valid,
  output logic [m-1:0] o_result,
  output logic [1:0]   o_status
);

  localparam int CW = $clog2(m + 1);
  localparam int SW = $clog2(m);
  localparam logic [CW-1:0] LAST_ITER = CW'(m);
  localparam logic [m-1:0]  M_LIMIT   = m'(m);

  // EXEC is the single evaluation cycle of the one-cycle ops
  typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]  cnt_reg;
  logic [n-1:0]   op_reg;
  logic [m-1:0]   a_reg, b_reg;
  logic           neg_reg;
  logic [2*m-1:0] acc_reg, mcand_reg;
  logic [m-1:0]   work_reg, dvsr_reg, rem_reg;

  logic           accept, is_multi_in, iter_done, load_result;
  logic           op_hi_in, op_hi_reg;
  logic [m:0]     rem_shift;
  logic [m-1:0]   rem_sub;
  logic           div_fits;
  logic [2*m-1:0] prod;
  logic [m-1:0]   hi_diff;
  logic [m-1:0]   sum, diff, shl_res, shl_back, quot;
  logic [SW-1:0]  sh_amt;
  logic           shl_bad;
  logic [m-1:0]   fin_res;
  logic           fin_err, fin_ovf;
  logic [1:0]     fin_status;

  function automatic logic [m-1:0] mag(input logic [m-1:0] x);
    return x[m-1] ? -x : x;
  endfunction

  // Opcode bits above the defined range make the operation invalid
  if (n > 3) begin : g_wide_op
    assign op_hi_in  = |i_oper[n-1:3];
    assign op_hi_reg = |op_reg[n-1:3];
  end else begin : g_narrow_op
    assign op_hi_in  = 1'b0;
    assign op_hi_reg = 1'b0;
  end

  assign accept      = (state_reg == IDLE) && i_valid;
  assign is_multi_in = !op_hi_in && (i_oper[2:1] == 2'b11);
  assign iter_done   = (cnt_reg == LAST_ITER);
  assign load_result = (state_reg == EXEC) || ((state_reg == BUSY) && iter_done);

  assign o_ready = (state_reg == IDLE);
  assign o_valid = (state_reg == DONE);

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_valid) state_next = is_multi_in ? BUSY : EXEC;
      EXEC:    state_next = DONE;
      BUSY:    if (iter_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  assign rem_shift = {rem_reg, work_reg[m-1]};
  assign div_fits  = (rem_shift >= {1'b0, dvsr_reg});
  assign rem_sub   = rem_shift[m-1:0] - dvsr_reg;

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      neg_reg   <= 1'b0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      work_reg  <= '0;
      dvsr_reg  <= '0;
      rem_reg   <= '0;
      o_result  <= '0;
      o_status  <= 2'b00;
    end else begin
      if (accept) begin
        op_reg    <= i_oper;
        a_reg     <= i_argA;
        b_reg     <= i_argB;
        neg_reg   <= i_argA[m-1] ^ i_argB[m-1];
        cnt_reg   <= '0;
        acc_reg   <= '0;
        rem_reg   <= '0;
        mcand_reg <= {{m{1'b0}}, mag(i_argA)};
        dvsr_reg  <= mag(i_argB);
        // multiplier for mul, dividend for div
        work_reg  <= i_oper[0] ? mag(i_argA) : mag(i_argB);
      end else if ((state_reg == BUSY) && !iter_done) begin
        cnt_reg <= cnt_reg + CW'(1);
        if (!op_reg[0]) begin
          if (work_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg <= mcand_reg << 1;
          work_reg  <= work_reg >> 1;
        end else begin
          rem_reg  <= div_fits ? rem_sub : rem_shift[m-1:0];
          work_reg <= {work_reg[m-2:0], div_fits};
        end
      end
      if (load_result) begin
        o_result <= fin_res;
        o_status <= fin_status;
      end
    end
  end

  assign prod = neg_reg ? -acc_reg : acc_reg;

  // Product fits in m signed bits only if its upper half replicates bit m-1
  for (genvar gi = m; gi < 2 * m; gi++) begin : g_prod_ovf
    assign hi_diff[gi-m] = prod[gi] ^ prod[m-1];
  end

  assign sum      = a_reg + b_reg;
  assign diff     = a_reg - b_reg;
  assign sh_amt   = b_reg[SW-1:0];
  assign shl_res  = a_reg << sh_amt;
  assign shl_back = $signed(shl_res) >>> sh_amt;
  assign shl_bad  = b_reg[m-1] || (b_reg >= M_LIMIT);
  assign quot     = neg_reg ? -work_reg : work_reg;

  always_comb begin
    fin_res = '0;
    fin_err = 1'b0;
    fin_ovf = 1'b0;
    if (op_hi_reg) begin
      fin_err = 1'b1;
    end else begin
      case (op_reg[2:0])
        3'd0: begin
          fin_res = sum;
          fin_ovf = (a_reg[m-1] == b_reg[m-1]) && (sum[m-1] != a_reg[m-1]);
        end
        3'd1: begin
          fin_res = diff;
          fin_ovf = (a_reg[m-1] != b_reg[m-1]) && (diff[m-1] != a_reg[m-1]);
        end
        3'd2: fin_res = a_reg & b_reg;
        3'd3: fin_res = a_reg | b_reg;
        3'd4: fin_res = a_reg ^ b_reg;
        3'd5: begin
          if (shl_bad) begin
            fin_err = 1'b1;
          end else begin
            fin_res = shl_res;
            fin_ovf = (shl_back != a_reg);
          end
        end
        3'd6: begin
          fin_res = prod[m-1:0];
          fin_ovf = |hi_diff;
        end
        3'd7: begin
          if (b_reg == '0) begin
            fin_err = 1'b1;
          end else begin
            fin_res = quot;
            // only -2^(m-1) / -1 yields a positive magnitude with the MSB set
            fin_ovf = !neg_reg && work_reg[m-1];
          end
        end
        default: fin_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    fin_status = 2'b00;
    if (fin_err)              fin_status = 2'b11;
    else if (fin_ovf)         fin_status = 2'b10;
    else if (fin_res == '0)   fin_status = 2'b01;
  end

endmodule

// File: tb/tb_exe_unit_w2.sv
// Self-checking bench for exe_unit_w2 (m=8, n=3): vector table driven through a
// result scoreboard, plus reset-in-flight and request-while-busy sequences.
module tb_exe_unit_w2;

  localparam int M = 8;
  localparam int N = 3;
  localparam int NV = 23;

  logic         i_clk = 1'b0;
  logic         i_rsn = 1'b0;
  logic         i_valid = 1'b0;
  logic [N-1:0] i_oper = '0;
  logic [M-1:0] i_argA = '0;
  logic [M-1:0] i_argB = '0;
  logic         o_ready;
  logic         o_valid;
  logic [M-1:0] o_result;
  logic [1:0]   o_status;

  exe_unit_w2 #(.m(M), .n(N)) dut (
    .i_clk    (i_clk),
    .i_rsn    (i_rsn),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_oper   (i_oper),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_status (o_status)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [1:0] st;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [1:0] st;
    int         due;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs [NV];
  int   n_chk = 0;
  int   n_fail = 0;
  int   tick_cnt = 0;
  int   valid_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Advance to the next falling edge and score any completed result there.
  task automatic tick();
    exp_t e;
    @(negedge i_clk);
    tick_cnt++;
    if (o_valid === 1'b1) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: o_valid=1 with no request pending at tick %0d", tick_cnt);
      end else begin
        e = sb_q.pop_front();
        $display("txn %s: result=%02h status=%b tick=%0d", e.tag, o_result, o_status, tick_cnt);
        chk({e.tag, " result"}, 32'(o_result), 32'(e.res));
        chk({e.tag, " status"}, 32'(o_status), 32'(e.st));
        chk({e.tag, " latency"}, 32'(tick_cnt), 32'(e.due));
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 40 && o_ready !== 1'b1; k++) tick();
    chk({tag, " ready_before_issue"}, 32'(o_ready), 32'd1);
  endtask

  task automatic issue(input vec_t v, input string tag);
    int low;
    wait_ready(tag);
    i_oper  = v.op;
    i_argA  = v.a;
    i_argB  = v.b;
    i_valid = 1'b1;
    sb_q.push_back('{v.res, v.st, tick_cnt + v.lat + 1, tag});
    tick();
    i_valid = 1'b0;
    low = (o_ready === 1'b0) ? 1 : 0;
    for (int k = 0; k < 40 && o_ready !== 1'b1; k++) begin
      tick();
      if (o_ready === 1'b0) low++;
    end
    chk({tag, " busy_cycles"}, 32'(low), 32'(v.lat + 1));
    chk({tag, " completed"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    vecs[0]  = '{3'd0, 8'h64, 8'h32, 8'h96, 2'b10, 1};
    vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 2'b01, 1};
    vecs[2]  = '{3'd4, 8'hF0, 8'h3C, 8'hCC, 2'b00, 1};
    vecs[3]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 2'b00, 1};
    vecs[4]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 2'b00, 1};
    vecs[5]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 2'b10, 1};
    vecs[6]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 2'b10, 1};
    vecs[7]  = '{3'd0, 8'hF0, 8'h10, 8'h00, 2'b01, 1};
    vecs[8]  = '{3'd6, 8'hF9, 8'h06, 8'hD6, 2'b00, 9};
    vecs[9]  = '{3'd6, 8'h14, 8'h0A, 8'hC8, 2'b10, 9};
    vecs[10] = '{3'd6, 8'h80, 8'hFF, 8'h80, 2'b10, 9};
    vecs[11] = '{3'd6, 8'hF0, 8'h08, 8'h80, 2'b00, 9};
    vecs[12] = '{3'd6, 8'h00, 8'h05, 8'h00, 2'b01, 9};
    vecs[13] = '{3'd7, 8'h9C, 8'h07, 8'hF2, 2'b00, 9};
    vecs[14] = '{3'd7, 8'h05, 8'h00, 8'h00, 2'b11, 9};
    vecs[15] = '{3'd7, 8'h80, 8'hFF, 8'h80, 2'b10, 9};
    vecs[16] = '{3'd7, 8'h07, 8'hFE, 8'hFD, 2'b00, 9};
    vecs[17] = '{3'd7, 8'hFF, 8'h02, 8'h00, 2'b01, 9};
    vecs[18] = '{3'd5, 8'h03, 8'h02, 8'h0C, 2'b00, 1};
    vecs[19] = '{3'd5, 8'h40, 8'h01, 8'h80, 2'b10, 1};
    vecs[20] = '{3'd5, 8'h01, 8'hFF, 8'h00, 2'b11, 1};
    vecs[21] = '{3'd5, 8'h01, 8'h08, 8'h00, 2'b11, 1};
    vecs[22] = '{3'd5, 8'h01, 8'h07, 8'h80, 2'b10, 1};

    // Reset state
    tick();
    tick();
    chk("reset o_ready", 32'(o_ready), 32'd1);
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_result", 32'(o_result), 32'd0);
    chk("reset o_status", 32'(o_status), 32'd0);
    i_rsn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i], $sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    // Reset while a multiply is iterating: result dropped, outputs cleared at once
    wait_ready("rst_mul");
    i_oper  = 3'd6;
    i_argA  = 8'hF9;
    i_argB  = 8'h06;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_mul busy", 32'(o_ready), 32'd0);
    chk("rst_mul result_held", 32'(o_result), 32'(vecs[NV-1].res));
    chk("rst_mul status_held", 32'(o_status), 32'(vecs[NV-1].st));
    vc0 = valid_cnt;
    #2 i_rsn = 1'b0;
    #1;
    chk("rst_mul async o_ready", 32'(o_ready), 32'd1);
    chk("rst_mul async o_valid", 32'(o_valid), 32'd0);
    chk("rst_mul async o_result", 32'(o_result), 32'd0);
    chk("rst_mul async o_status", 32'(o_status), 32'd0);
    tick();
    i_rsn = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    chk("rst_mul no_valid", 32'(valid_cnt - vc0), 32'd0);

    // i_valid held through BUSY: only the first request completes
    wait_ready("hold_mul");
    vc0 = valid_cnt;
    i_oper  = 3'd6;
    i_argA  = 8'h03;
    i_argB  = 8'h05;
    i_valid = 1'b1;
    sb_q.push_back('{8'h0F, 2'b00, tick_cnt + 10, "hold_mul"});
    tick();
    i_oper = 3'd0;
    i_argA = 8'h01;
    i_argB = 8'h01;
    for (int k = 0; k < 9; k++) tick();
    i_valid = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("hold_mul valid_pulses", 32'(valid_cnt - vc0), 32'd1);
    chk("hold_mul completed", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
